ulpi_rx_decoder: RTL

- Receive-side stage alongside the ULPI link controller. Samples the PHY-driven bus (dir/nxt/data) and decodes RX CMD bytes into registered line status.
- Frames USB receive data bytes into a byte stream with last and error markers.
- Captures the data byte returned by a PHY register read.
- Output consumers: the USB packet layer (byte stream) and the link controller (status, register read data).

---
 rtl/ulpi_rx_decoder_pkg.sv | 30 +++
 rtl/ulpi_rx_decoder_if.sv | 37 +++
 rtl/ulpi_rx_hold.sv | 71 +++++++
 rtl/ulpi_rx_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ulpi_rx_decoder_pkg.sv
// Shared types and constants for the ULPI receive path.
// Holds the decoder states, the RX CMD event codes and the RX CMD bit positions.
package ulpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN,
        ST_RX,
        ST_REG_DATA,
        ST_REG_WAIT_LOW
    } ulpi_rx_state_t;

    typedef enum logic [1:0] {
        EV_NONE      = 2'b00,
        EV_ACTIVE    = 2'b01,
        EV_HOST_DISC = 2'b10,
        EV_ERROR     = 2'b11
    } ulpi_rx_event_t;

    localparam int RXCMD_LS_LSB   = 0;
    localparam int RXCMD_VBUS_LSB = 2;
    localparam int RXCMD_EV_LSB   = 4;
    localparam int RXCMD_ID_BIT   = 6;
    localparam int RXCMD_ALT_BIT  = 7;

    // PID + 1024 payload bytes + CRC16
    localparam int DEF_MAX_PKT_LEN = 1027;
    localparam int DEF_LEN_W       = 11;

endpackage

// File: rtl/ulpi_rx_decoder_if.sv
// PHY-side sampled bus plus the decoded outputs of the ULPI receive decoder.
// master drives the PHY inputs and observes results; slave is the decoder.
interface ulpi_rx_decoder_if;
    logic       i_dir;
    logic       i_nxt;
    logic [7:0] i_data;
    logic       i_reg_rd_pend;

    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_err;
    logic       o_rx_active;
    logic [1:0] o_linestate;
    logic [1:0] o_vbus;
    logic       o_host_disc;
    logic       o_id;
    logic       o_alt_int;
    logic       o_rxcmd_valid;
    logic [7:0] o_reg_data;
    logic       o_reg_valid;
    logic       o_reg_abort;

    modport master (
        output i_dir, i_nxt, i_data, i_reg_rd_pend,
        input  o_valid, o_data, o_last, o_err, o_rx_active, o_linestate, o_vbus,
               o_host_disc, o_id, o_alt_int, o_rxcmd_valid, o_reg_data,
               o_reg_valid, o_reg_abort
    );

    modport slave (
        input  i_dir, i_nxt, i_data, i_reg_rd_pend,
        output o_valid, o_data, o_last, o_err, o_rx_active, o_linestate, o_vbus,
               o_host_disc, o_id, o_alt_int, o_rxcmd_valid, o_reg_data,
               o_reg_valid, o_reg_abort
    );
endinterface

// File: rtl/ulpi_rx_hold.sv
// One-byte lookahead: a byte is released only once its successor (push) or the
// end of packet (flush) is known, so the final byte can carry last/err.
module ulpi_rx_hold (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_flush,
    input  logic       i_err,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_err
);

    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic       err_q, err_d;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        last_d     = 1'b0;
        err_d      = 1'b0;
        if (i_push) begin
            if (hold_vld_q) begin
                valid_d = 1'b1;
                data_d  = hold_q;
            end
            hold_d     = i_push_data;
            hold_vld_d = 1'b1;
        end else if (i_flush) begin
            if (hold_vld_q) begin
                valid_d = 1'b1;
                data_d  = hold_q;
                last_d  = 1'b1;
                err_d   = i_err;
            end
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_err   = err_q;

endmodule

// File: rtl/ulpi_rx_decoder.sv
// ULPI receive decoder: RX CMD line status, framed RX byte stream with
// last/err markers, and capture of PHY register read data.
module ulpi_rx_decoder
    import ulpi_pkg::*;
#(
    parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
    parameter int LEN_W       = DEF_LEN_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    ulpi_rx_decoder_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

    ulpi_rx_state_t   state_q, state_d;
    logic             rx_active_q, rx_active_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;
    logic [1:0]       linestate_q, linestate_d;
    logic [1:0]       vbus_q, vbus_d;
    logic             host_disc_q, host_disc_d;
    logic             id_q, id_d;
    logic             alt_int_q, alt_int_d;
    logic             rxcmd_valid_q, rxcmd_valid_d;
    logic [7:0]       reg_data_q, reg_data_d;
    logic             reg_valid_q, reg_valid_d;
    logic             reg_abort_q, reg_abort_d;

    logic           push, eop;
    ulpi_rx_event_t ev;

    assign ev = ulpi_rx_event_t'(bus.i_data[RXCMD_EV_LSB +: 2]);

    always_comb begin
        state_d       = state_q;
        rx_active_d   = rx_active_q;
        cnt_d         = cnt_q;
        perr_d        = perr_q;
        linestate_d   = linestate_q;
        vbus_d        = vbus_q;
        host_disc_d   = host_disc_q;
        id_d          = id_q;
        alt_int_d     = alt_int_q;
        rxcmd_valid_d = 1'b0;
        reg_data_d    = reg_data_q;
        reg_valid_d   = 1'b0;
        reg_abort_d   = 1'b0;
        push          = 1'b0;
        eop           = 1'b0;

        case (state_q)
            ST_IDLE: if (bus.i_dir) state_d = ST_TURN;

            ST_TURN: begin
                if (!bus.i_dir) begin
                    state_d = ST_IDLE;
                end else if (bus.i_nxt) begin
                    rx_active_d = 1'b1;
                    cnt_d       = '0;
                    perr_d      = 1'b0;
                    state_d     = ST_RX;
                end else if (bus.i_reg_rd_pend) begin
                    state_d = ST_REG_DATA;
                end else begin
                    state_d = ST_RX;
                end
            end

            ST_RX: begin
                if (!bus.i_dir) begin
                    eop     = rx_active_q;
                    state_d = ST_IDLE;
                end else if (bus.i_nxt) begin
                    push        = 1'b1;
                    rx_active_d = 1'b1;
                    if (cnt_q >= MAX_LEN) perr_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + LEN_W'(1);
                end else begin
                    linestate_d   = bus.i_data[RXCMD_LS_LSB +: 2];
                    vbus_d        = bus.i_data[RXCMD_VBUS_LSB +: 2];
                    id_d          = bus.i_data[RXCMD_ID_BIT];
                    alt_int_d     = bus.i_data[RXCMD_ALT_BIT];
                    host_disc_d   = (ev == EV_HOST_DISC);
                    rxcmd_valid_d = 1'b1;
                    case (ev)
                        EV_ACTIVE: rx_active_d = 1'b1;
                        EV_ERROR: begin
                            rx_active_d = 1'b1;
                            perr_d      = 1'b1;
                        end
                        default: eop = rx_active_q;
                    endcase
                end
            end

            ST_REG_DATA: begin
                if (bus.i_dir) begin
                    reg_data_d  = bus.i_data;
                    reg_valid_d = 1'b1;
                    state_d     = ST_REG_WAIT_LOW;
                end else begin
                    reg_abort_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_REG_WAIT_LOW: if (!bus.i_dir) state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // End of packet: the hold stage releases its byte as last using perr_q
        if (eop) begin
            rx_active_d = 1'b0;
            cnt_d       = '0;
            perr_d      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            rx_active_q   <= 1'b0;
            cnt_q         <= '0;
            perr_q        <= 1'b0;
            linestate_q   <= '0;
            vbus_q        <= '0;
            host_disc_q   <= 1'b0;
            id_q          <= 1'b0;
            alt_int_q     <= 1'b0;
            rxcmd_valid_q <= 1'b0;
            reg_data_q    <= '0;
            reg_valid_q   <= 1'b0;
            reg_abort_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_active_q   <= rx_active_d;
            cnt_q         <= cnt_d;
            perr_q        <= perr_d;
            linestate_q   <= linestate_d;
            vbus_q        <= vbus_d;
            host_disc_q   <= host_disc_d;
            id_q          <= id_d;
            alt_int_q     <= alt_int_d;
            rxcmd_valid_q <= rxcmd_valid_d;
            reg_data_q    <= reg_data_d;
            reg_valid_q   <= reg_valid_d;
            reg_abort_q   <= reg_abort_d;
        end
    end

    logic       s_valid, s_last, s_err;
    logic [7:0] s_data;

    ulpi_rx_hold u_hold (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (bus.i_data),
        .i_flush     (eop),
        .i_err       (perr_q),
        .o_valid     (s_valid),
        .o_data      (s_data),
        .o_last      (s_last),
        .o_err       (s_err)
    );

    assign bus.o_valid       = s_valid;
    assign bus.o_data        = s_data;
    assign bus.o_last        = s_last;
    assign bus.o_err         = s_err;
    assign bus.o_rx_active   = rx_active_q;
    assign bus.o_linestate   = linestate_q;
    assign bus.o_vbus        = vbus_q;
    assign bus.o_host_disc   = host_disc_q;
    assign bus.o_id          = id_q;
    assign bus.o_alt_int     = alt_int_q;
    assign bus.o_rxcmd_valid = rxcmd_valid_q;
    assign bus.o_reg_data    = reg_data_q;
    assign bus.o_reg_valid   = reg_valid_q;
    assign bus.o_reg_abort   = reg_abort_q;

endmodule
